// File: rtl/subtrator_serial_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
//   start     - request a new subtraction (honoured only when the engine is idle)
//   A, B      - minuend / subtrahend, captured on the accepted-start edge
//   BorrowIn  - initial borrow, captured on the accepted-start edge
//   busy      - operation in progress
//   done      - one-cycle pulse, D/BorrowOut just updated
//   D         - difference, held between operations
//   BorrowOut - final borrow, held between operations
interface subtrator_serial_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         BorrowIn;
  logic         busy;
  logic         done;
  logic [N-1:0] D;
  logic         BorrowOut;

  modport master (
    output start, A, B, BorrowIn,
    input  busy, done, D, BorrowOut
  );

  modport slave (
    input  start, A, B, BorrowIn,
    output busy, done, D, BorrowOut
  );
endinterface

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor: {BorrowOut, D} = A - B - BorrowIn, one bit per clock, LSB first.
// A single full-subtractor cell is fed from the operand shift registers and a registered borrow.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset (priority over start)
//   bus - slave side of subtrator_serial_if (start/A/B/BorrowIn in, busy/done/D/BorrowOut out)
module subtrator_serial #(
  parameter int unsigned N = 8
) (
  input logic              clk,
  input logic              rst,
  subtrator_serial_if.slave bus
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    res_q, res_d;
  logic            borrow_q, borrow_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    diff_q, diff_d;
  logic            bout_q, bout_d;
  logic            done_q, done_d;

  // Full-subtractor cell on the current LSBs and the registered borrow.
  logic cell_d;
  logic cell_bout;
  assign cell_d    = a_q[0] ^ b_q[0] ^ borrow_q;
  assign cell_bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);

  // Difference bits enter at the MSB so the LSB-first stream lands in order after N shifts.
  logic [N-1:0] res_shifted;
  if (N == 1) begin : g_res_one
    assign res_shifted = cell_d;
  end else begin : g_res_many
    assign res_shifted = {cell_d, res_q[N-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d      = bus.A;
          b_d      = bus.B;
          borrow_d = bus.BorrowIn;
          res_d    = '0;
          cnt_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = res_shifted;
        borrow_d = cell_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          diff_d  = res_shifted;
          bout_d  = cell_bout;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy      = (state_q == StShift);
  assign bus.done      = done_q;
  assign bus.D         = diff_q;
  assign bus.BorrowOut = bout_q;

endmodule

// File: doc/subtrator_serial.md
Name: subtrator_serial

Overview:
- Bit-serial N-bit subtractor; computes A − B − BorrowIn, one bit per clock, LSB first.
- Contains one full-subtractor cell (D = a^b^bin; Bout = (~a&b) | (~(a^b)&bin)) plus a registered borrow that feeds that cell back each cycle.
- Sits directly around the 1-bit full-subtractor stage: sequences operand bits into it and consumes its BorrowOut as the next bit's BorrowIn.
- Start/done handshake to the surrounding datapath; the result is held stable between operations.

Parameters:
- N, 8, operand and result width in bits (N ≥ 1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new subtraction; sampled only in IDLE.
- A  input  N  minuend; captured on the accepted-start edge.
- B  input  N  subtrahend; captured on the accepted-start edge.
- BorrowIn  input  1  initial borrow; captured on the accepted-start edge.
- busy  output  1  high while the operation is in progress (state SHIFT).
- done  output  1  one-cycle pulse: result valid.
- D  output  N  difference; updates only at completion.
- BorrowOut  output  1  final borrow; updates only at completion.

Behaviour:
- Reset: rst sampled high at a clock edge forces state IDLE. After that edge:
  - busy = 0, done = 0, D = 0, BorrowOut = 0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - rst has priority over start.
- States: IDLE and SHIFT.
- IDLE, start = 1 at edge e0:
  - Load shift registers with A and B; load the borrow flop with BorrowIn; set counter to 0.
  - Go to SHIFT; busy = 1 after e0.
- IDLE, start = 0: hold. D and BorrowOut keep their last values.
- SHIFT, each edge (e1..eN):
  - Apply the full-subtractor equations to a0 = LSB(A shift), b0 = LSB(B shift) and the borrow flop.
  - Shift the difference bit into the MSB of the result shift register; shift A and B right.
  - borrow flop ← Bout; counter increments.
- Completion edge eN (counter = N−1 on entry):
  - D ← full result register including the bit from this edge; BorrowOut ← Bout.
  - done ← 1; busy ← 0; state ← IDLE.
- done deasserts on the following edge unless a new completion occurs.
- Latency: done and the new result are visible N cycles after the start edge. Throughput: one operation every N cycles.
- Arithmetic: {BorrowOut, D} = (A − B − BorrowIn) mod 2^(N+1). BorrowOut = 1 iff A < B + BorrowIn (unsigned).
- start while busy = 1 is ignored; operands are not re-sampled.
- start high in the done cycle (state already IDLE) is accepted:
  - The next operation begins at that edge.
  - done drops and busy rises on the same edge.
  - D and BorrowOut keep the previous result until the next completion.
- Reset mid-SHIFT aborts the operation: no done pulse; D and BorrowOut are cleared to 0.
- A, B and BorrowIn may change freely after the start edge without affecting the result.
- Counter width: clog2(N) bits, minimum 1. N = 1 completes on e1.

Test Plan:
- N=8: A=0x5A, B=0x3C, BorrowIn=0, start pulse → busy for 8 cycles; done pulse on the 8th edge with D=0x1E, BorrowOut=0.
- N=8, borrow propagation:
  - 0x00 − 0x01 − 0 → D=0xFF, BorrowOut=1.
  - 0x10 − 0x0F − 1 → D=0x00, BorrowOut=0.
  - 0xFF − 0xFF − 1 → D=0xFF, BorrowOut=1.
- N=1, all 8 combinations of A, B, BorrowIn → D and BorrowOut match the full-subtractor truth table. Example: A=0, B=1, BorrowIn=1 → D=0, BorrowOut=1.
- N=8 back-to-back and ignored starts:
  - start held high through the done cycle with new operands 0x80, 0x01, 0 → second done exactly 8 cycles later with D=0x7F.
  - start pulses during busy are ignored; operands changed mid-operation do not alter the result.
- N=8, reset mid-operation: rst asserted at the 4th SHIFT edge → next cycle busy=0, done=0, D=0, BorrowOut=0, no done pulse. A fresh start then completes normally.
- Random: 1000 random A, B, BorrowIn with N=8 and N=13 → every result matches the reference expression; exactly one done per accepted start.
